decode_execute_ctrl_stage: RTL and testbench

DECODE_EXECUTE_CTRL_STAGE -- requirements
Module: decode_execute_ctrl_stage

---
 rtl/decode_execute_ctrl_stage.sv | 148 ++++++++++++++
 tb/tb_decode_execute_ctrl_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_ctrl_stage.sv
// Decode-to-execute control register with branch/jump resolution and a one-edge kill after a redirect.
// Optional feature macro: DECODE_EXECUTE_REDIRECT_CNT_EN adds the redirectCnt output.
module decode_execute_ctrl_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regWriteD,
    input  logic             memWriteD,
    input  logic             ALUSrcD,
    input  logic             luiD,
    input  logic [1:0]       resultSrcD,
    input  logic [1:0]       jumpD,
    input  logic [2:0]       branchD,
    input  logic [2:0]       ALUControlD,
    input  logic             stallE,
    input  logic             flushE,
    input  logic             zeroE,
    input  logic             ltE,
    output logic             regWriteE,
    output logic             memWriteE,
    output logic             ALUSrcE,
    output logic             luiE,
    output logic [1:0]       resultSrcE,
    output logic [1:0]       jumpE,
    output logic [2:0]       branchE,
    output logic [2:0]       ALUControlE,
    output logic             validE,
    output logic [1:0]       pcSrcE,
`ifdef DECODE_EXECUTE_REDIRECT_CNT_EN
    output logic [CNT_W-1:0] redirectCnt,
`endif
    output logic             redirectE
);

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       lui;
        logic [1:0] result_src;
        logic [1:0] jump;
        logic [2:0] branch;
        logic [2:0] alu_ctrl;
    } ctrl_t;

    localparam logic [2:0] BR_BEQ   = 3'b001;
    localparam logic [2:0] BR_BNE   = 3'b010;
    localparam logic [2:0] BR_BLT   = 3'b011;
    localparam logic [2:0] BR_BGE   = 3'b100;
    localparam logic [1:0] JMP_JAL  = 2'b01;
    localparam logic [1:0] JMP_JALR = 2'b10;

    if (CNT_W < 1) begin : g_cnt_w_invalid
    end

    ctrl_t      w_ctrl_d;
    ctrl_t      r_ctrl;
    logic       r_valid;
    logic       r_kill;
    logic       w_taken;
    logic [1:0] w_pc_src;
    logic       w_redirect;
    logic       w_redirect_accept;

    assign w_ctrl_d = '{reg_write: regWriteD, mem_write: memWriteD, alu_src: ALUSrcD,
                        lui: luiD, result_src: resultSrcD, jump: jumpD,
                        branch: branchD, alu_ctrl: ALUControlD};

    // Flush outranks the pending kill, which outranks stall: a killed slot must drain even while stalled.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
        end else if (flushE || r_kill) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
        end else if (!stallE) begin
            r_ctrl  <= w_ctrl_d;
            r_valid <= 1'b1;
        end
    end

    // A redirect only counts once the stage can advance; while stalled it is simply held.
    assign w_redirect_accept = w_redirect && !stallE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kill <= 1'b0;
        end else begin
            r_kill <= w_redirect_accept;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves w_taken unassigned (no latch).
        w_taken = 1'b0;
        unique case (r_ctrl.branch)
            BR_BEQ:  w_taken = zeroE;
            BR_BNE:  w_taken = !zeroE;
            BR_BLT:  w_taken = ltE;
            BR_BGE:  w_taken = !ltE;
            default: w_taken = 1'b0;
        endcase
    end

    // Reserved branch/jump encodings fall through to sequential fetch.
    always_comb begin
        w_pc_src = 2'b00;
        if (!rst && r_valid) begin
            if (r_ctrl.jump == JMP_JALR) begin
                w_pc_src = 2'b10;
            end else if (r_ctrl.jump == JMP_JAL || w_taken) begin
                w_pc_src = 2'b01;
            end
        end
    end

    assign w_redirect = |w_pc_src;

`ifdef DECODE_EXECUTE_REDIRECT_CNT_EN
    logic [CNT_W-1:0] r_redirect_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_cnt <= '0;
        end else if (w_redirect_accept) begin
            r_redirect_cnt <= r_redirect_cnt + 1'b1;
        end
    end

    assign redirectCnt = r_redirect_cnt;
`endif

    assign regWriteE   = r_ctrl.reg_write;
    assign memWriteE   = r_ctrl.mem_write;
    assign ALUSrcE     = r_ctrl.alu_src;
    assign luiE        = r_ctrl.lui;
    assign resultSrcE  = r_ctrl.result_src;
    assign jumpE       = r_ctrl.jump;
    assign branchE     = r_ctrl.branch;
    assign ALUControlE = r_ctrl.alu_ctrl;
    assign validE      = r_valid;
    assign pcSrcE      = w_pc_src;
    assign redirectE   = w_redirect;

endmodule

// File: tb/tb_decode_execute_ctrl_stage.sv
// Directed self-checking bench for decode_execute_ctrl_stage; counter checks run when
// DECODE_EXECUTE_REDIRECT_CNT_EN is defined.
module tb_decode_execute_ctrl_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       regWriteD, memWriteD, ALUSrcD, luiD;
    logic [1:0] resultSrcD, jumpD;
    logic [2:0] branchD, ALUControlD;
    logic       stallE, flushE, zeroE, ltE;
    logic       regWriteE, memWriteE, ALUSrcE, luiE;
    logic [1:0] resultSrcE, jumpE;
    logic [2:0] branchE, ALUControlE;
    logic       validE;
    logic [1:0] pcSrcE;
    logic       redirectE;
`ifdef DECODE_EXECUTE_REDIRECT_CNT_EN
    logic [3:0] redirectCnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_execute_ctrl_stage #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .regWriteD(regWriteD), .memWriteD(memWriteD), .ALUSrcD(ALUSrcD), .luiD(luiD),
        .resultSrcD(resultSrcD), .jumpD(jumpD), .branchD(branchD), .ALUControlD(ALUControlD),
        .stallE(stallE), .flushE(flushE), .zeroE(zeroE), .ltE(ltE),
        .regWriteE(regWriteE), .memWriteE(memWriteE), .ALUSrcE(ALUSrcE), .luiE(luiE),
        .resultSrcE(resultSrcE), .jumpE(jumpE), .branchE(branchE), .ALUControlE(ALUControlE),
        .validE(validE), .pcSrcE(pcSrcE),
`ifdef DECODE_EXECUTE_REDIRECT_CNT_EN
        .redirectCnt(redirectCnt),
`endif
        .redirectE(redirectE)
    );

    // Control word packed as {regWrite, memWrite, ALUSrc, lui, resultSrc, jump, branch, ALUControl}.
    logic [14:0] e_word;
    assign e_word = {regWriteE, memWriteE, ALUSrcE, luiE, resultSrcE, jumpE, branchE, ALUControlE};

    function automatic logic [14:0] mk(input logic rw, input logic mw, input logic as, input logic lu,
                                       input logic [1:0] rs, input logic [1:0] j,
                                       input logic [2:0] b, input logic [2:0] a);
        return {rw, mw, as, lu, rs, j, b, a};
    endfunction

    task automatic drive(input logic [14:0] w);
        {regWriteD, memWriteD, ALUSrcD, luiD, resultSrcD, jumpD, branchD, ALUControlD} = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bubble with stall held so any pending kill is cleared as well.
    task automatic clean();
        flushE = 1'b1;
        stallE = 1'b1;
        tick();
        flushE = 1'b0;
        stallE = 1'b0;
    endtask

    logic [14:0] w_alu, w_mem, w_other, w_nop_y;
    logic [3:0]  exp_cnt;

    initial begin
        w_alu   = mk(1, 0, 0, 0, 2'b01, 2'b00, 3'b000, 3'b010);
        w_mem   = mk(0, 1, 1, 1, 2'b10, 2'b00, 3'b000, 3'b101);
        w_other = mk(1, 0, 0, 0, 2'b11, 2'b00, 3'b000, 3'b111);
        w_nop_y = mk(1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 3'b011);

        rst = 1'b1; stallE = 1'b0; flushE = 1'b0; zeroE = 1'b0; ltE = 1'b0;
        drive('0);
        tick();
        check("reset_word", e_word, 15'h0);
        check("reset_valid", validE, 1'b0);
        check("reset_pcsrc", pcSrcE, 2'b00);
        check("reset_redirect", redirectE, 1'b0);

        // Basic load, one-cycle latency
        rst = 1'b0;
        drive(w_alu);
        tick();
        check("load_word", e_word, w_alu);
        check("load_valid", validE, 1'b1);
        check("load_pcsrc", pcSrcE, 2'b00);
        drive(w_mem);
        tick();
        check("load_word2", e_word, w_mem);

        // Stall holds everything
        stallE = 1'b1;
        drive(w_other);
        tick();
        check("stall_word", e_word, w_mem);
        check("stall_valid", validE, 1'b1);
        stallE = 1'b0;

        // Taken beq: redirect, kill set, bubble one edge later despite valid D
        drive(mk(0, 0, 0, 0, 2'b00, 2'b00, 3'b001, 3'b000));
        tick();
        check("beq_not_taken", pcSrcE, 2'b00);
        zeroE = 1'b1;
        #1;
        check("beq_taken_pcsrc", pcSrcE, 2'b01);
        check("beq_taken_redirect", redirectE, 1'b1);
        drive(w_nop_y);
        tick();
        check("beq_after_word", e_word, w_nop_y);
        check("beq_after_pcsrc", pcSrcE, 2'b00);
        tick();
        check("beq_kill_valid", validE, 1'b0);
        check("beq_kill_word", e_word, 15'h0);
        tick();
        check("beq_resume_valid", validE, 1'b1);
        zeroE = 1'b0;
        clean();

        // bne / blt / jal
        drive(mk(0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 3'b000));
        tick();
        check("bne_taken", pcSrcE, 2'b01);
        zeroE = 1'b1;
        #1;
        check("bne_not_taken", pcSrcE, 2'b00);
        zeroE = 1'b0;
        clean();
        ltE = 1'b1;
        drive(mk(0, 0, 0, 0, 2'b00, 2'b00, 3'b011, 3'b000));
        tick();
        check("blt_taken", pcSrcE, 2'b01);
        ltE = 1'b0;
        #1;
        check("blt_not_taken", pcSrcE, 2'b00);
        clean();
        drive(mk(1, 0, 0, 0, 2'b10, 2'b01, 3'b000, 3'b000));
        tick();
        check("jal_pcsrc", pcSrcE, 2'b01);
        check("jal_jumpE", jumpE, 2'b01);
        clean();

        // Reserved encodings pass through but never redirect
        drive(mk(1, 1, 0, 0, 2'b00, 2'b11, 3'b111, 3'b001));
        tick();
        check("rsv_word", e_word, mk(1, 1, 0, 0, 2'b00, 2'b11, 3'b111, 3'b001));
        check("rsv_pcsrc", pcSrcE, 2'b00);
        clean();
        zeroE = 1'b1; ltE = 1'b1;
        drive(mk(0, 0, 0, 0, 2'b00, 2'b00, 3'b110, 3'b000));
        tick();
        check("br110_branchE", branchE, 3'b110);
        check("br110_pcsrc", pcSrcE, 2'b00);
        check("br110_redirect", redirectE, 1'b0);
        drive(w_nop_y);
        tick();
        check("br110_no_kill", validE, 1'b1);
        tick();
        check("br110_no_kill2", validE, 1'b1);
        zeroE = 1'b0; ltE = 1'b0;
        clean();

        // jalr under a two-cycle stall: pcSrc held three cycles, kill only after stall drops
        drive(mk(0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 3'b000));
        tick();
        check("jalr_c1", pcSrcE, 2'b10);
        stallE = 1'b1;
        drive(w_nop_y);
        tick();
        check("jalr_c2", pcSrcE, 2'b10);
        tick();
        check("jalr_c3", pcSrcE, 2'b10);
        check("jalr_c3_valid", validE, 1'b1);
        stallE = 1'b0;
        tick();
        check("jalr_release_word", e_word, w_nop_y);
        check("jalr_release_valid", validE, 1'b1);
        stallE = 1'b1;
        tick();
        check("jalr_kill_over_stall", validE, 1'b0);
        stallE = 1'b0;
        tick();
        check("jalr_resume", e_word, w_nop_y);
        check("jalr_resume_valid", validE, 1'b1);
        clean();

        // flush + stall over a taken bge: bubble, kill cleared, no extra bubble
        drive(mk(0, 0, 0, 0, 2'b00, 2'b00, 3'b100, 3'b000));
        tick();
        check("bge_taken", pcSrcE, 2'b01);
        flushE = 1'b1; stallE = 1'b1;
        drive(w_nop_y);
        tick();
        check("fs_valid", validE, 1'b0);
        check("fs_word", e_word, 15'h0);
        check("fs_pcsrc", pcSrcE, 2'b00);
        flushE = 1'b0; stallE = 1'b0;
        tick();
        check("fs_no_extra_bubble", validE, 1'b1);
        check("fs_word_after", e_word, w_nop_y);

        // Reset in the middle of a redirect
        zeroE = 1'b1;
        drive(mk(0, 0, 0, 0, 2'b00, 2'b00, 3'b001, 3'b000));
        tick();
        check("rstmid_redirect", redirectE, 1'b1);
        rst = 1'b1;
        #1;
        check("rstmid_pcsrc_in_rst", pcSrcE, 2'b00);
        check("rstmid_redirect_in_rst", redirectE, 1'b0);
        tick();
        check("rstmid_valid", validE, 1'b0);
        rst = 1'b0;
        drive(w_nop_y);
        tick();
        check("rstmid_first_load", validE, 1'b1);
        check("rstmid_first_word", e_word, w_nop_y);
        zeroE = 1'b0;

`ifdef DECODE_EXECUTE_REDIRECT_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("cnt_reset", redirectCnt, 4'd0);
        exp_cnt = 4'd0;
        zeroE = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(mk(0, 0, 0, 0, 2'b00, 2'b00, 3'b001, 3'b000));
            tick();
            drive(w_nop_y);
            tick();
            exp_cnt = exp_cnt + 4'd1;
            tick();
            if (i == 14) check("cnt_15", redirectCnt, exp_cnt);
        end
        check("cnt_wrap", redirectCnt, 4'd1);
        drive(mk(0, 0, 0, 0, 2'b00, 2'b00, 3'b001, 3'b000));
        tick();
        rst = 1'b1;
        tick();
        check("cnt_rst_mid", redirectCnt, 4'd0);
        rst = 1'b0;
        zeroE = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
